// File: rtl/pb_uart_7seg.sv
// pb_uart_7seg: 8N1 UART receiver feeding a CRC-32 (IEEE 802.3, reflected,
// poly EDB88320) over 4-byte frames, with an 8-digit multiplexed hex display
// of either the frame CRC or the last received frame word.
// Optional build macro CRC_ECHO_TX_EN: echo each completed CRC on uart_tx_o,
// MSB byte first, 8N1. Without it uart_tx_o is constant high.
module pb_uart_7seg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int SCAN_BITS = 16
) (
  input  logic       clk_50m,
  input  logic       sw_rst,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  input  logic       led_disp_switch,
  output logic [7:0] leds_o,
  output logic [7:0] sels_o
);

  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t         r_rx_state;
  rx_state_t         w_rx_next;
  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  logic [CW-1:0]     r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_rx_byte;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_crc_run;
  logic [31:0]       r_data_word;
  logic [31:0]       r_disp_word;
  logic [31:0]       crc;
  logic [SCAN_BITS-1:0] r_scan_cnt;
  logic [7:0]        r_leds;
  logic [7:0]        r_sels;

  logic              w_fall;
  logic              w_baud_tc;
  logic              w_ld_half;
  logic              w_ld_full;
  logic              w_shift;
  logic              w_byte_ok;
  logic              w_frame_done;
  logic [31:0]       w_crc_next;
  logic [31:0]       w_word_next;
  logic [2:0]        w_digit;
  logic [31:0]       w_disp_src;
  logic [3:0]        w_nibble;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Two-flop synchronizer plus a delayed copy for start-edge detection
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall    = r_rx_prev & ~r_rx_sync;
  assign w_baud_tc = (r_baud_cnt == '0);

  // RX FSM state register
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX FSM next state
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: if (w_baud_tc) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baud_tc && (r_bit_cnt == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_baud_tc) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX FSM outputs: timer loads, bit shift and byte-accept strobes
  always_comb begin
    w_ld_half = 1'b0;
    w_ld_full = 1'b0;
    w_shift   = 1'b0;
    w_byte_ok = 1'b0;
    case (r_rx_state)
      RX_IDLE:  w_ld_half = w_fall;
      RX_START: w_ld_full = w_baud_tc & ~r_rx_sync;
      RX_DATA: begin
        w_shift   = w_baud_tc;
        w_ld_full = w_baud_tc;
      end
      RX_STOP:  w_byte_ok = w_baud_tc & r_rx_sync;
      default: ;
    endcase
  end

  // Bit timer (down-counter, terminal count at zero), bit counter and shifter
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_rx_byte  <= 8'h00;
    end else begin
      if (w_ld_half)      r_baud_cnt <= HALF_LD;
      else if (w_ld_full) r_baud_cnt <= FULL_LD;
      else if (!w_baud_tc) r_baud_cnt <= r_baud_cnt - 1'b1;
      if (w_ld_half)    r_bit_cnt <= 3'd0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift) r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
    end
  end

  assign w_crc_next   = crc32_byte(r_crc_run, r_rx_byte);
  assign w_word_next  = {r_data_word[23:0], r_rx_byte};
  assign w_frame_done = w_byte_ok & (r_byte_cnt == 2'd3);

  // Frame assembly: running CRC, data word, and latched results on the 4th byte
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) begin
      r_byte_cnt  <= 2'd0;
      r_crc_run   <= 32'hFFFFFFFF;
      r_data_word <= 32'h0;
      r_disp_word <= 32'h0;
      crc         <= 32'h0;
    end else if (w_byte_ok) begin
      r_data_word <= w_word_next;
      r_byte_cnt  <= r_byte_cnt + 2'd1;
      if (w_frame_done) begin
        crc         <= ~w_crc_next;
        r_disp_word <= w_word_next;
        r_crc_run   <= 32'hFFFFFFFF;
      end else begin
        r_crc_run <= w_crc_next;
      end
    end
  end

  assign w_digit    = r_scan_cnt[SCAN_BITS-1 -: 3];
  assign w_disp_src = led_disp_switch ? r_disp_word : crc;
  assign w_nibble   = w_disp_src[{w_digit, 2'b00} +: 4];

  // Display scan; outputs registered so they sit at all-off during reset
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) begin
      r_scan_cnt <= '0;
      r_leds     <= 8'hFF;
      r_sels     <= 8'hFF;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
      r_leds     <= hex_glyph(w_nibble);
      r_sels     <= ~(8'd1 << w_digit);
    end
  end

  assign leds_o = r_leds;
  assign sels_o = r_sels;

`ifdef CRC_ECHO_TX_EN
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t     r_tx_state;
  tx_state_t     w_tx_next;
  logic [23:0]   r_tx_word;
  logic [9:0]    r_tx_shift;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [1:0]    r_tx_byte;
  logic          r_tx_line;
  logic          w_tx_tc;
  logic          w_tx_start;
  logic          w_tx_adv;
  logic          w_tx_line;
  logic [31:0]   w_tx_crc;

  assign w_tx_tc  = (r_tx_cnt == '0);
  assign w_tx_crc = ~w_crc_next;

  // TX FSM state register
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX FSM next state; frames completing mid-echo are not queued
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (w_frame_done) w_tx_next = TX_SEND;
      TX_SEND: if (w_tx_tc && (r_tx_bit == 4'd9) && (r_tx_byte == 2'd3)) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX FSM outputs
  always_comb begin
    w_tx_start = 1'b0;
    w_tx_adv   = 1'b0;
    w_tx_line  = 1'b1;
    case (r_tx_state)
      TX_IDLE: w_tx_start = w_frame_done;
      TX_SEND: begin
        w_tx_adv  = w_tx_tc;
        w_tx_line = r_tx_shift[0];
      end
      default: ;
    endcase
  end

  // TX datapath: 10-bit frame shifter per byte, remaining bytes queued in r_tx_word
  always_ff @(posedge clk_50m or posedge sw_rst) begin
    if (sw_rst) begin
      r_tx_word  <= 24'h0;
      r_tx_shift <= 10'h3FF;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 4'd0;
      r_tx_byte  <= 2'd0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_line <= w_tx_line;
      if (w_tx_start) begin
        r_tx_word  <= w_tx_crc[23:0];
        r_tx_shift <= {1'b1, w_tx_crc[31:24], 1'b0};
        r_tx_cnt   <= FULL_LD;
        r_tx_bit   <= 4'd0;
        r_tx_byte  <= 2'd0;
      end else if (w_tx_adv) begin
        r_tx_cnt <= FULL_LD;
        if (r_tx_bit == 4'd9) begin
          r_tx_bit   <= 4'd0;
          r_tx_byte  <= r_tx_byte + 2'd1;
          r_tx_shift <= {1'b1, r_tx_word[23:16], 1'b0};
          r_tx_word  <= {r_tx_word[15:0], 8'h00};
        end else begin
          r_tx_bit   <= r_tx_bit + 4'd1;
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        end
      end else if (r_tx_state == TX_SEND) begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end
    end
  end

  assign uart_tx_o = r_tx_line;
`else
  assign uart_tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_pb_uart_7seg.sv
// Directed bench for pb_uart_7seg. The UART runs at 500 kbaud (100 clocks per
// bit) and the scan counter is shortened so the run stays brief; frame and
// display behaviour do not depend on either value.
module tb_pb_uart_7seg;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD      = 500000;
  localparam int SCAN_BITS = 6;
  localparam int DIV       = (CLK_FREQ + BAUD / 2) / BAUD;

  logic       clk_50m = 1'b0;
  logic       sw_rst = 1'b1;
  logic       uart_rx_i = 1'b1;
  logic       uart_tx_o;
  logic       led_disp_switch = 1'b0;
  logic [7:0] leds_o;
  logic [7:0] sels_o;

  int checks = 0;
  int failures = 0;
  int tx_low = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  pb_uart_7seg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCAN_BITS(SCAN_BITS)) dut (
    .clk_50m(clk_50m),
    .sw_rst(sw_rst),
    .uart_rx_i(uart_rx_i),
    .uart_tx_o(uart_tx_o),
    .led_disp_switch(led_disp_switch),
    .leds_o(leds_o),
    .sels_o(sels_o)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) if (uart_tx_o !== 1'b1) tx_low++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx_i = 1'b0;
    repeat (DIV) @(negedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (DIV) @(negedge clk_50m);
    end
    uart_rx_i = stop_bit;
    repeat (DIV) @(negedge clk_50m);
    uart_rx_i = 1'b1;
    repeat (DIV / 4) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_digit(input int k);
    logic [7:0] exp_sel;
    int n;
    exp_sel = ~(8'd1 << k);
    n = 0;
    @(negedge clk_50m);
    @(negedge clk_50m);
    while (sels_o !== exp_sel && n < 2000) begin
      @(negedge clk_50m);
      n++;
    end
    chk("scan_digit", {24'h0, sels_o}, {24'h0, exp_sel});
  endtask

`ifdef CRC_ECHO_TX_EN
  task automatic capture_tx(input logic [31:0] exp_w);
    logic [7:0] b;
    int n;
    for (int k = 3; k >= 0; k--) begin
      n = 0;
      while (uart_tx_o !== 1'b0 && n < DIV * 60) begin
        @(negedge clk_50m);
        n++;
      end
      repeat (DIV / 2) @(negedge clk_50m);
      chk("tx_start", {31'h0, uart_tx_o}, 32'h0);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk_50m);
        b[i] = uart_tx_o;
      end
      repeat (DIV) @(negedge clk_50m);
      chk("tx_byte", {24'h0, b}, {24'h0, exp_w[k*8 +: 8]});
      chk("tx_stop", {31'h0, uart_tx_o}, 32'h1);
    end
  endtask
`endif

  initial begin
    // 1: reset values, then one-hot-low scan with blank crc
    repeat (3) @(negedge clk_50m);
    chk("rst_sels", {24'h0, sels_o}, 32'h000000FF);
    chk("rst_leds", {24'h0, leds_o}, 32'h000000FF);
    chk("rst_tx", {31'h0, uart_tx_o}, 32'h1);
    chk("rst_crc", dut.crc, 32'h0);
    repeat (2) @(negedge clk_50m);
    sw_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      repeat (13) @(negedge clk_50m);
      chk("scan_onehot", $countones(~sels_o), 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      wait_digit(k);
      chk("leds_zero", {24'h0, leds_o}, {24'h0, glyph[0]});
    end

    // 2: reference frame, display of crc and of the data word
`ifdef CRC_ECHO_TX_EN
    fork
      send_frame(32'hC9034AF6);
      capture_tx(32'h760F306F);
    join
`else
    send_frame(32'hC9034AF6);
`endif
    chk("crc_frame1", dut.crc, 32'h760F306F);
    wait_digit(0);
    chk("leds_crc_d0", {24'h0, leds_o}, 32'h0000008E);
    wait_digit(7);
    chk("leds_crc_d7", {24'h0, leds_o}, 32'h000000F8);
    led_disp_switch = 1'b1;
    wait_digit(0);
    chk("leds_data_d0", {24'h0, leds_o}, 32'h00000082);
    wait_digit(7);
    chk("leds_data_d7", {24'h0, leds_o}, 32'h000000C6);
    chk("crc_hold", dut.crc, 32'h760F306F);

    // 3: short glitch must not start a byte, then an all-zero frame
    uart_rx_i = 1'b0;
    repeat (DIV / 4) @(negedge clk_50m);
    uart_rx_i = 1'b1;
    repeat (DIV * 2) @(negedge clk_50m);
    send_frame(32'h00000000);
    chk("crc_zero", dut.crc, 32'h2144DF1C);
    for (int k = 0; k < 8; k++) begin
      wait_digit(k);
      chk("leds_data0", {24'h0, leds_o}, 32'h000000C0);
    end
    led_disp_switch = 1'b0;
    wait_digit(0);
    chk("leds_zcrc_d0", {24'h0, leds_o}, 32'h000000C6);

    // 4: framing error discards the byte
    send_byte(8'hC9, 1'b0);
    repeat (DIV) @(negedge clk_50m);
    chk("crc_after_ferr", dut.crc, 32'h2144DF1C);
    send_frame(32'hC9034AF6);
    chk("crc_frame_ferr", dut.crc, 32'h760F306F);

    // 5: reset mid-frame drops the partial frame
    send_frame(32'h00000000);
    chk("crc_zero2", dut.crc, 32'h2144DF1C);
    send_byte(8'hC9, 1'b1);
    send_byte(8'h03, 1'b1);
    chk("crc_partial", dut.crc, 32'h2144DF1C);
    sw_rst = 1'b1;
    repeat (5) @(negedge clk_50m);
    chk("crc_midrst", dut.crc, 32'h0);
    chk("sels_midrst", {24'h0, sels_o}, 32'h000000FF);
    sw_rst = 1'b0;
    repeat (DIV) @(negedge clk_50m);
    send_frame(32'hC9034AF6);
    chk("crc_after_rst", dut.crc, 32'h760F306F);

    // 6: without the echo option the line never leaves idle
`ifndef CRC_ECHO_TX_EN
    chk("tx_idle", tx_low, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pb_uart_7seg.md
Name: pb_uart_7seg

Overview:
- Top-level UART-to-CRC demo block on a 50 MHz board.
- Receives a 4-byte frame on an 8N1 UART and computes the standard CRC-32 (IEEE 802.3) over those bytes.
- Holds the result in an internal 32-bit register named `crc`, which benches probe hierarchically.
- Shows either the CRC or the received word on an 8-digit multiplexed 7-segment display.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, UART bit rate. Divisor = CLK_FREQ/BAUD, rounded = 434 clocks per bit.
- SCAN_BITS, 16, width of the display scan counter. Digit period = 2^SCAN_BITS clocks.

Ports:
- clk_50m  input  1  system clock, single clock domain.
- sw_rst  input  1  asynchronous, active-high reset.
- uart_rx_i  input  1  UART receive line, idle high, asynchronous to clk_50m.
- uart_tx_o  output  1  UART transmit line, idle high.
- led_disp_switch  input  1  0 = display `crc`; 1 = display received data word.
- leds_o  output  8  segments, active-low: bit7 = dp, bit6..0 = g,f,e,d,c,b,a.
- sels_o  output  8  digit enables, active-low: bit0 = rightmost digit (nibble 0).

Behaviour:
- Reset (async, active-high) sets:
  - `crc` = 0, data word = 0, running CRC = FFFFFFFF, byte count = 0.
  - RX FSM = IDLE, scan counter = 0, uart_tx_o = 1, leds_o = FF, sels_o = FF.
- Reset asserted mid-byte or mid-frame aborts everything; partially received bytes are lost.
- RX synchronisation: uart_rx_i passes through a 2-flop synchronizer before use.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge starts a half-bit (217-clock) wait.
  - START: line re-checked at mid start bit; if high, treat as a glitch and return to IDLE.
  - DATA: 8 bits sampled LSB first, each at mid-bit, 434 clocks apart.
  - STOP: sampled at mid-bit. 1 = byte accepted. 0 = framing error, byte discarded, byte count and running CRC unchanged.
- Frame handling:
  - Byte count 0..3; at count 0 the running CRC is FFFFFFFF.
  - Each accepted byte shifts into the data word MSB-first: first byte lands in [31:24].
  - Running CRC update per byte: reflected algorithm, polynomial EDB88320, processed LSB first. Bit-serial (8 clocks) or byte-parallel implementations are both acceptable.
- Frame completion (4th byte accepted):
  - `crc` <= ~running CRC.
  - Data word becomes the displayed word.
  - Byte count returns to 0 and running CRC re-initialises to FFFFFFFF.
  - Latency: `crc` updated no later than 10 clocks after the 4th stop-bit sample.
  - `crc` holds its value until the next frame completes.
- No inter-byte timeout: a frame may span arbitrary idle time.
- Display:
  - Free-running scan counter; the top 3 bits select a digit.
  - sels_o drives exactly one bit low at a time.
  - leds_o = hex glyph of the selected nibble; dp always off.
  - Glyphs 0-F in standard hex shapes (A, b, C, d, E, F); e.g. F = 8E, 0 = C0.
  - led_disp_switch is sampled combinationally and takes effect on the next displayed digit.

Optional Feature:
- Macro CRC_ECHO_TX_EN.
- Defined:
  - On frame completion, a TX FSM sends the 4 CRC bytes MSB-byte first, each 8N1 at BAUD.
  - A new frame completing during transmission is ignored for echo; `crc` still updates.
- Undefined: uart_tx_o is tied to 1 and no TX logic exists.

Test Plan:
1. Assert sw_rst 100 ns, release -> uart_tx_o = 1, `crc` = 00000000, sels_o = FF during reset, one-hot-low scan afterwards.
2. Send bytes C9, 03, 4A, F6 at 115200 8N1 (bit time 8680/8681 ns) -> `crc` = 760F306F within 2 clocks after the final idle bit; with switch = 0, digit 0 shows F (leds_o = 8E).
3. Send 00, 00, 00, 00 -> `crc` = 2144DF1C; with led_disp_switch = 1, all digits show 0 (leds_o = C0).
4. Send C9 with stop bit = 0, then C9, 03, 4A, F6 -> the bad byte is discarded and `crc` = 760F306F.
5. Send 2 bytes, assert sw_rst, then send full frame C9, 03, 4A, F6 -> `crc` = 760F306F.
6. With CRC_ECHO_TX_EN, send C9, 03, 4A, F6 -> uart_tx_o emits 76, 0F, 30, 6F in 8N1; without the macro, uart_tx_o stays 1.
